// File: rtl/seg7_scan_scheduler_if.sv
// Load handshake between the BCD counter (master) and the scan scheduler (slave).
// Carries one full digit set per transfer; bits [3:0] hold digit 0.
interface seg7_scan_scheduler_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    load_valid;
  logic                    load_ready;
  logic [4*NUM_DIGITS-1:0] load_data;

  modport master (output load_valid, output load_data, input load_ready);
  modport slave  (input load_valid, input load_data, output load_ready);
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Time-multiplexed seven-segment scan controller with a double-buffered digit set
// that is swapped in only at frame boundaries, plus live leading-zero blanking.
module seg7_scan_scheduler #(
  parameter int NUM_DIGITS   = 4,
  parameter int DWELL_CYCLES = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_lzb_en,
  seg7_scan_scheduler_if.slave    load_if,
  output logic [6:0]              o_segments,
  output logic [NUM_DIGITS-1:0]   o_dig_en,
  output logic                    o_frame_done
);
  localparam int IW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int MAXC = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam int DW   = 4 * NUM_DIGITS;

  localparam logic [0:0]    ST_SHOW    = 1'b0;
  localparam logic [0:0]    ST_BLANK   = 1'b1;
  localparam logic [IW-1:0] LAST_IDX   = IW'(NUM_DIGITS - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [0:0]            r_phase;
  logic [IW-1:0]         r_idx;
  logic [CW-1:0]         r_cnt;
  logic [DW-1:0]         r_disp;
  logic [DW-1:0]         r_shadow;
  logic                  r_pending;

  logic                  w_boundary;
  logic                  w_accept;
  logic                  w_zero_run;
  logic [NUM_DIGITS-1:0] w_blank;
  logic [NUM_DIGITS-1:0] w_onehot;
  logic                  w_cur_blank;
  logic [3:0]            w_cur_code;
  logic [6:0]            w_segments;
  logic [NUM_DIGITS-1:0] w_dig_en;

  function automatic logic [6:0] seg_decode(input logic [3:0] code);
    logic [6:0] seg;
    case (code)
      4'd0:    seg = 7'h3F;
      4'd1:    seg = 7'h06;
      4'd2:    seg = 7'h5B;
      4'd3:    seg = 7'h4F;
      4'd4:    seg = 7'h66;
      4'd5:    seg = 7'h6D;
      4'd6:    seg = 7'h7D;
      4'd7:    seg = 7'h07;
      4'd8:    seg = 7'h7F;
      4'd9:    seg = 7'h6F;
      default: seg = 7'h40;
    endcase
    return seg;
  endfunction

  assign w_boundary = (r_phase == ST_BLANK) && (r_idx == LAST_IDX) && (r_cnt == BLANK_LAST);
  assign w_accept   = load_if.load_valid && !r_pending;

  // Scan sequencer: dwell on a digit, then dead-time, then advance the index.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_phase <= ST_SHOW;
      r_idx   <= '0;
      r_cnt   <= '0;
    end else if (r_phase == ST_SHOW) begin
      if (r_cnt == DWELL_LAST) begin
        r_phase <= ST_BLANK;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end else begin
      if (r_cnt == BLANK_LAST) begin
        r_phase <= ST_SHOW;
        r_cnt   <= '0;
        r_idx   <= (r_idx == LAST_IDX) ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Double buffer: accept into the shadow, promote to the display only at a frame boundary.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp    <= '0;
      r_shadow  <= '0;
      r_pending <= 1'b0;
    end else if (w_boundary && r_pending) begin
      r_disp    <= r_shadow;
      r_pending <= 1'b0;
    end else if (w_accept) begin
      r_shadow  <= load_if.load_data;
      r_pending <= 1'b1;
    end else begin
      r_pending <= r_pending;
    end
  end

  // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    w_blank    = '0;
    w_zero_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_zero_run = w_zero_run && (r_disp[4*k +: 4] == 4'd0);
      if (k != 0) begin
        w_blank[k] = i_lzb_en && w_zero_run;
      end else begin
        w_blank[k] = 1'b0;
      end
    end
  end

  // Select the active digit's code and blank flag.
  always_comb begin
    w_onehot    = '0;
    w_cur_code  = 4'd0;
    w_cur_blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      w_onehot[k] = (r_idx == IW'(k));
      w_cur_code  = (r_idx == IW'(k)) ? r_disp[4*k +: 4] : w_cur_code;
      w_cur_blank = (r_idx == IW'(k)) ? w_blank[k] : w_cur_blank;
    end
  end

  // Output drive; the dead-time forces everything dark.
  always_comb begin
    w_dig_en   = '0;
    w_segments = 7'h00;
    if (r_phase == ST_SHOW) begin
      w_dig_en = w_onehot;
      if (w_cur_blank) begin
        w_segments = 7'h00;
      end else begin
        w_segments = seg_decode(w_cur_code);
      end
    end else begin
      w_dig_en   = '0;
      w_segments = 7'h00;
    end
  end

  assign o_segments         = w_segments;
  assign o_dig_en           = w_dig_en;
  assign o_frame_done       = w_boundary;
  assign load_if.load_ready = ~r_pending;
endmodule

// File: tb/tb_seg7_scan_scheduler.sv
// Scoreboard bench: a frame-position reference model predicts every cycle's outputs,
// a negedge monitor pops and compares them against the scan scheduler.
module tb_seg7_scan_scheduler;
  localparam int N  = 4;
  localparam int D  = 4;
  localparam int B  = 2;
  localparam int DP = D + B;
  localparam int FR = N * DP;

  typedef struct {
    logic [6:0] seg;
    logic [3:0] dig;
    logic       rdy;
    logic       fd;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       lzb = 1'b0;
  logic [6:0] seg;
  logic [3:0] dig;
  logic       fd;

  seg7_scan_scheduler_if #(.NUM_DIGITS(N)) u_if ();

  seg7_scan_scheduler #(.NUM_DIGITS(N), .DWELL_CYCLES(D), .BLANK_CYCLES(B)) u_dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_lzb_en     (lzb),
    .load_if      (u_if),
    .o_segments   (seg),
    .o_dig_en     (dig),
    .o_frame_done (fd)
  );

  always #5 clk = ~clk;

  logic [6:0] lut [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};

  int         t;
  logic [3:0] m_disp [N];
  logic [15:0] m_shadow;
  bit         m_pending;
  bit         m_acc;
  int         tests = 0;
  int         fails = 0;
  exp_t       q [$];

  function automatic exp_t expect_now();
    exp_t e;
    int p, k;
    bit show, blank;
    p = t % FR;
    k = p / DP;
    show = (p % DP) < D;
    blank = (lzb == 1'b1) && (k != 0);
    for (int j = k; j < N; j++) if (m_disp[j] != 4'd0) blank = 1'b0;
    e.dig = show ? 4'(1 << k) : 4'd0;
    e.seg = (show && !blank) ? lut[m_disp[k]] : 7'h00;
    e.rdy = !m_pending;
    e.fd  = (p == FR - 1);
    return e;
  endfunction

  task automatic step();
    q.push_back(expect_now());
    @(posedge clk);
    m_acc = 1'b0;
    if (rst) begin
      t = 0;
      m_shadow = 16'h0000;
      m_pending = 1'b0;
      for (int j = 0; j < N; j++) m_disp[j] = 4'd0;
    end else begin
      if ((t % FR == FR - 1) && m_pending) begin
        for (int j = 0; j < N; j++) m_disp[j] = m_shadow[4*j +: 4];
        m_pending = 1'b0;
      end else if (u_if.load_valid && !m_pending) begin
        m_shadow = u_if.load_data;
        m_pending = 1'b1;
        m_acc = 1'b1;
      end
      t = (t + 1) % FR;
    end
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic send(input logic [15:0] d);
    int n;
    n = 0;
    u_if.load_valid = 1'b1;
    u_if.load_data  = d;
    do begin
      step();
      n++;
    end while (!m_acc && n < 3 * FR);
    if (!m_acc) begin
      fails++;
      $display("FAIL send_timeout: data %04h not taken within %0d cycles", d, 3 * FR);
    end
    u_if.load_valid = 1'b0;
  endtask

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %02h expected %02h", name, $time, act, exp);
    end
  endtask

  // Monitor: compare every presented output cycle against the oldest prediction.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      check("segments", {1'b0, seg}, {1'b0, e.seg});
      check("dig_en", {4'h0, dig}, {4'h0, e.dig});
      check("load_ready", {7'h00, u_if.load_ready}, {7'h00, e.rdy});
      check("frame_done", {7'h00, fd}, {7'h00, e.fd});
    end
  end

  initial begin
    logic [15:0] d;
    u_if.load_valid = 1'b0;
    u_if.load_data  = 16'h0000;
    t = 0;
    m_shadow = 16'h0000;
    m_pending = 1'b0;
    for (int j = 0; j < N; j++) m_disp[j] = 4'd0;
    @(posedge clk);
    #1;
    run(5);
    rst = 1'b0;
    run(2 * FR);

    send(16'h1234);
    send(16'h5678);
    run(3 * FR);

    lzb = 1'b1;
    send(16'h0070);
    run(2 * FR);
    send(16'h0000);
    run(2 * FR);
    lzb = 1'b0;
    run(FR);

    lzb = 1'b1;
    send(16'hA0FB);
    run(2 * FR);

    send(16'h1111);
    run(5);
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(3 * FR);

    for (int it = 0; it < 25; it++) begin
      lzb = 1'($urandom_range(0, 1));
      d = 16'h0000;
      for (int j = 0; j < N; j++)
        d[4*j +: 4] = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      send(d);
      for (int g = $urandom_range(0, 40); g > 0; g--) begin
        if ($urandom_range(0, 15) == 0) lzb = ~lzb;
        step();
      end
      if ($urandom_range(0, 7) == 0) begin
        rst = 1'b1;
        run($urandom_range(1, 3));
        rst = 1'b0;
      end
    end
    run(FR);

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d predictions left unchecked", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
